// File: rtl/fg_island_prog_sequencer.sv
// Program/tunnel sequencer for one floating-gate crossbar island.
// FG_PROG_VERIFY_EN enables closed-loop pulse-then-verify; undefined gives open-loop max-pulse programming.
module fg_island_prog_sequencer #(
   parameter int ROWS   = 8,
   parameter int COLS   = 16,
   parameter int ROW_AW = $clog2(ROWS),
   parameter int COL_AW = $clog2(COLS),
   parameter int PW     = 16,
   parameter int SETTLE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ROW_AW-1:0] cmd_row,
   input  logic [COL_AW-1:0] cmd_col,
   input  logic [PW-1:0]     cmd_pulse_len,
   input  logic [PW-1:0]     cmd_max_pulses,
   input  logic              verify_hit,
   output logic [ROWS-1:0]   row_sel,
   output logic [COLS-1:0]   col_sel,
   output logic              prog_mode,
   output logic              vinj_en,
   output logic              tun_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [PW-1:0]     pulses_used
);

   localparam int TW = (PW > $clog2(SETTLE + 1)) ? PW : $clog2(SETTLE + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_PULSE   = 3'd2;
   localparam logic [2:0] S_RECOVER = 3'd3;
   localparam logic [2:0] S_VERIFY  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [31:0]     ROWS_U  = 32'(ROWS);
   localparam logic [31:0]     COLS_U  = 32'(COLS);
   localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);
   localparam logic [COLS-1:0] COL_ONE = COLS'(1);

   logic [2:0]        r_state;
   logic              r_op;
   logic [ROW_AW-1:0] r_row;
   logic [COL_AW-1:0] r_col;
   logic [PW-1:0]     r_len_m1;
   logic [PW-1:0]     r_max;
   logic [PW-1:0]     r_cnt;
   logic [TW-1:0]     r_tmr;
   logic              r_err;

   logic              w_accept;
   logic              w_range_bad;
   logic              w_tmr_zero;
   logic              w_last;
   logic              w_active;
   logic [TW-1:0]     w_settle;
   logic [TW-1:0]     w_len;
   logic [PW-1:0]     w_cmd_len_m1;
   logic [PW-1:0]     w_cmd_max;

   assign w_accept     = cmd_valid && (r_state == S_IDLE);
   assign w_range_bad  = !cmd_op && ((32'(cmd_row) >= ROWS_U) || (32'(cmd_col) >= COLS_U));
   assign w_tmr_zero   = (r_tmr == '0);
   assign w_last       = (r_cnt == r_max);
   assign w_settle     = TW'(SETTLE - 1);
   assign w_len        = TW'(r_len_m1);
   // Zero length/limit fields are promoted to 1 so the timer and counter never underflow.
   assign w_cmd_len_m1 = (cmd_pulse_len == '0) ? '0 : cmd_pulse_len - PW'(1);
   assign w_cmd_max    = (cmd_max_pulses == '0) ? PW'(1) : cmd_max_pulses;

`ifndef FG_PROG_VERIFY_EN
   logic w_unused_verify;
   assign w_unused_verify = verify_hit;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= 1'b0;
         r_row    <= '0;
         r_col    <= '0;
         r_len_m1 <= '0;
         r_max    <= PW'(1);
         r_cnt    <= '0;
         r_tmr    <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op     <= cmd_op;
                  r_row    <= cmd_row;
                  r_col    <= cmd_col;
                  r_len_m1 <= w_cmd_len_m1;
                  r_max    <= w_cmd_max;
                  r_cnt    <= '0;
                  r_tmr    <= w_settle;
                  r_err    <= w_range_bad;
                  r_state  <= w_range_bad ? S_DONE : S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_tmr_zero) begin
                  r_state <= S_PULSE;
                  r_tmr   <= w_len;
                  r_cnt   <= r_cnt + PW'(1);
               end else begin
                  r_tmr <= r_tmr - TW'(1);
               end
            end
            S_PULSE: begin
               if (w_tmr_zero) begin
                  r_state <= S_RECOVER;
                  r_tmr   <= w_settle;
               end else begin
                  r_tmr <= r_tmr - TW'(1);
               end
            end
            S_RECOVER: begin
               if (!w_tmr_zero) begin
                  r_tmr <= r_tmr - TW'(1);
               end else if (r_op) begin
                  r_state <= S_DONE;
`ifdef FG_PROG_VERIFY_EN
               end else begin
                  r_state <= S_VERIFY;
               end
            end
            S_VERIFY: begin
               if (verify_hit) begin
                  r_state <= S_DONE;
                  r_err   <= 1'b0;
               end else if (w_last) begin
                  r_state <= S_DONE;
                  r_err   <= 1'b1;
               end else begin
                  r_state <= S_PULSE;
                  r_tmr   <= w_len;
                  r_cnt   <= r_cnt + PW'(1);
               end
            end
`else
               end else if (w_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_PULSE;
                  r_tmr   <= w_len;
                  r_cnt   <= r_cnt + PW'(1);
               end
            end
`endif
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_active    = (r_state == S_SETUP) || (r_state == S_PULSE) ||
                        (r_state == S_RECOVER) || (r_state == S_VERIFY);
   assign row_sel     = (w_active && !r_op) ? (ROW_ONE << r_row) : '0;
   assign col_sel     = (w_active && !r_op) ? (COL_ONE << r_col) : '0;
   assign prog_mode   = w_active;
   assign vinj_en     = (r_state == S_PULSE) && !r_op;
   assign tun_en      = (r_state == S_PULSE) && r_op;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign err         = (r_state == S_DONE) && r_err;
   assign cmd_ready   = (r_state == S_IDLE);
   assign pulses_used = r_cnt;

endmodule

// File: tb/tb_fg_island_prog_sequencer.sv
// Bench for fg_island_prog_sequencer: command table driven through a scoreboard, plus reset/hold sequences.
module tb_fg_island_prog_sequencer;

   localparam int S = 4;
`ifdef FG_PROG_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [3:0]  cmd_row;
   logic [4:0]  cmd_col;
   logic [15:0] cmd_pulse_len;
   logic [15:0] cmd_max_pulses;
   logic        verify_hit;
   logic [7:0]  row_sel;
   logic [15:0] col_sel;
   logic        prog_mode, vinj_en, tun_en, busy, done, err;
   logic [15:0] pulses_used;

   fg_island_prog_sequencer #(
      .ROWS(8), .COLS(16), .ROW_AW(4), .COL_AW(5), .PW(16), .SETTLE(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col),
      .cmd_pulse_len(cmd_pulse_len), .cmd_max_pulses(cmd_max_pulses),
      .verify_hit(verify_hit), .row_sel(row_sel), .col_sel(col_sel),
      .prog_mode(prog_mode), .vinj_en(vinj_en), .tun_en(tun_en), .busy(busy),
      .done(done), .err(err), .pulses_used(pulses_used)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [3:0]  row;
      logic [4:0]  col;
      logic [15:0] len;
      logic [15:0] maxp;
      int          hit_at;
      logic [7:0]  e_row;
      logic [15:0] e_col;
      logic        e_err;
      logic [15:0] e_pulses;
      int          e_lat;
      int          e_vinj;
      int          e_tun;
      int          e_npulse;
      int          e_setup;
   } vec_t;

   vec_t tbl[9];
   vec_t sb[$];
   vec_t cur;

   int n_vec = 0, n_fail = 0;
   int cyc = 0, acc_cyc = 0, accepts = 0, viol = 0;
   int vinj_cyc, tun_cyc, npulse, nsetup, cur_hit = 0;
   logic [7:0]  row_or;
   logic [15:0] col_or;
   bit prev_en, prev_pm, done_seen;

   function automatic vec_t mk(bit op, int row, int col, int len, int maxp, int hit,
                               int erow, int ecol, bit eerr, int epul, int elat,
                               int evinj, int etun, int enp, int esu);
      vec_t v;
      v.op = op; v.row = 4'(row); v.col = 5'(col); v.len = 16'(len); v.maxp = 16'(maxp);
      v.hit_at = hit; v.e_row = 8'(erow); v.e_col = 16'(ecol); v.e_err = eerr;
      v.e_pulses = 16'(epul); v.e_lat = elat; v.e_vinj = evinj; v.e_tun = etun;
      v.e_npulse = enp; v.e_setup = esu;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      bit hs;
      vec_t e;
      hs = cmd_valid && cmd_ready && rst_n;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
         accepts++; acc_cyc = cyc;
         vinj_cyc = 0; tun_cyc = 0; npulse = 0; nsetup = 0; row_or = '0; col_or = '0;
      end
      if (vinj_en && tun_en) viol++;
      if ((vinj_en || tun_en) && !prog_mode) viol++;
      if (err && !done) viol++;
      if (!busy && (row_sel != '0 || col_sel != '0 || prog_mode || vinj_en || tun_en || done)) viol++;
      if (vinj_en) vinj_cyc++;
      if (tun_en) tun_cyc++;
      if ((vinj_en || tun_en) && !prev_en) npulse++;
      if (prog_mode && !prev_pm) nsetup++;
      prev_en = vinj_en || tun_en;
      prev_pm = prog_mode;
      row_or |= row_sel;
      col_or |= col_sel;
      if (done) begin
         done_seen = 1'b1;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("err", err, e.e_err);
            chk("pulses_used", pulses_used, e.e_pulses);
            chk("latency", cyc - acc_cyc + 2, e.e_lat);
            chk("row_sel", row_or, e.e_row);
            chk("col_sel", col_or, e.e_col);
            chk("vinj_cycles", vinj_cyc, e.e_vinj);
            chk("tun_cycles", tun_cyc, e.e_tun);
            chk("pulse_count", npulse, e.e_npulse);
            chk("setup_count", nsetup, e.e_setup);
         end
      end
      verify_hit = (cur_hit != 0) && (npulse >= cur_hit);
   endtask

   task automatic run_cmd(input vec_t v, input bit hold);
      cur = v;
      cur_hit = v.hit_at;
      cmd_op = v.op; cmd_row = v.row; cmd_col = v.col;
      cmd_pulse_len = v.len; cmd_max_pulses = v.maxp;
      cmd_valid = 1'b1;
      sb.push_back(v);
      done_seen = 1'b0;
      accepts = 0;
      tick();
      if (!hold) cmd_valid = 1'b0;
      else begin
         cmd_op = 1'b1; cmd_row = 4'd5; cmd_col = 5'd6;
      end
      for (int i = 0; i < 5000 && !done_seen; i++) tick();
      if (!done_seen) begin
         n_vec++; n_fail++;
         $display("FAIL timeout: got no done expected done within 5000 cycles");
         sb.delete();
      end
      cmd_valid = 1'b0;
      tick();
      chk("idle_ready", cmd_ready, 1);
      chk("done_strobe", done, 0);
      chk("pulses_hold", pulses_used, v.e_pulses);
      if (hold) chk("held_accepts", accepts, 1);
   endtask

   initial begin
      //       op row col len  max hit  row    col      err         pulses      lat           vinj        tun  np          su
      tbl[0] = mk(0, 3, 10, 5,   4, 1, 'h08, 'h0400, 1'b0,        VER ? 1 : 4, VER ? 16 : 42, VER ? 5 : 20, 0, VER ? 1 : 4, 1);
      tbl[1] = mk(0, 3, 10, 5,   4, 0, 'h08, 'h0400, VER,         4,           VER ? 46 : 42, 20,           0, 4,           1);
      tbl[2] = mk(1, 5, 5,  100, 7, 1, 0,    0,      1'b0,        1,           110,           0,          100, 1,           1);
      tbl[3] = mk(0, 9, 0,  5,   4, 0, 0,    0,      1'b1,        0,           2,             0,            0, 0,           0);
      tbl[4] = mk(0, 0, 0,  0,   0, 0, 'h01, 'h0001, VER,         1,           VER ? 12 : 11, 1,            0, 1,           1);
      tbl[5] = mk(0, 7, 15, 2,   3, 2, 'h80, 'h8000, 1'b0,        VER ? 2 : 3, VER ? 20 : 24, VER ? 4 : 6,  0, VER ? 2 : 3, 1);
      tbl[6] = mk(0, 2, 16, 3,   2, 0, 0,    0,      1'b1,        0,           2,             0,            0, 0,           0);
      tbl[7] = mk(0, 8, 0,  3,   2, 0, 0,    0,      1'b1,        0,           2,             0,            0, 0,           0);
      tbl[8] = mk(0, 7, 15, 1,   1, 0, 'h80, 'h8000, VER,         1,           VER ? 12 : 11, 1,            0, 1,           1);

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_row = '0; cmd_col = '0;
      cmd_pulse_len = '0; cmd_max_pulses = '0; verify_hit = 1'b0;
      row_or = '0; col_or = '0; vinj_cyc = 0; tun_cyc = 0; npulse = 0; nsetup = 0;
      prev_en = 1'b0; prev_pm = 1'b0; done_seen = 1'b0;
      repeat (3) tick();
      chk("rst_outputs", {row_sel, col_sel, prog_mode, vinj_en, tun_en, busy, done, err}, 0);
      chk("rst_pulses_used", pulses_used, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", cmd_ready, 1);

      for (int i = 0; i < 9; i++) run_cmd(tbl[i], 1'b0);

      // Reset in the middle of a long injection pulse: command abandoned, no done.
      cur_hit = 0;
      cmd_op = 1'b0; cmd_row = 4'd1; cmd_col = 5'd1; cmd_pulse_len = 16'd50; cmd_max_pulses = 16'd2;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 50 && !vinj_en; i++) tick();
      chk("midrst_in_pulse", vinj_en, 1);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_outputs", {row_sel, col_sel, prog_mode, vinj_en, tun_en, busy, done, err}, 0);
      chk("midrst_pulses_used", pulses_used, 0);
      chk("midrst_ready", cmd_ready, 1);
      rst_n = 1'b1;
      repeat (8) tick();
      chk("midrst_idle", busy, 0);
      run_cmd(tbl[0], 1'b0);

      // cmd_valid held with changing fields while busy: only the first command is taken.
      run_cmd(tbl[4], 1'b1);

      chk("invariants", viol, 0);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fg_island_prog_sequencer.md
# fg_island_prog_sequencer

Parametrised programming sequencer for one floating-gate crossbar island (ROWS x COLS switch matrix). It accepts single-element program and island-wide tunnel commands, then drives the island's row/drain-select decoder, column/gate-mux decoder, program/run switch and injection/tunnel enables with settle and pulse timing. It adds iterative pulse-then-verify programming against an external readout comparator. It sits between the chip-level programming controller and the island's programming mux tiles.

## Interface
- ROWS, 8, matrix rows (drain-select lines); 2..64
- COLS, 16, matrix columns (gate-mux lines); 2..64
- ROW_AW, $clog2(ROWS), row address width
- COL_AW, $clog2(COLS), column address width
- PW, 16, width of pulse-length and pulse-count fields
- SETTLE, 4, settle cycles after switching decoders or ending a pulse; >=1
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high in IDLE; command accepted on cmd_valid & cmd_ready
- cmd_op  in  1  0 = PROGRAM element, 1 = TUNNEL (erase whole island)
- cmd_row  in  ROW_AW  target row (PROGRAM only)
- cmd_col  in  COL_AW  target column (PROGRAM only)
- cmd_pulse_len  in  PW  cycles per pulse; 0 treated as 1
- cmd_max_pulses  in  PW  pulse limit; 0 treated as 1
- verify_hit  in  1  readout comparator: element reached target
- row_sel  out  ROWS  one-hot drain select
- col_sel  out  COLS  one-hot gate-mux select
- prog_mode  out  1  program switches in program position
- vinj_en  out  1  injection pulse
- tun_en  out  1  tunnel pulse
- busy  out  1  not IDLE
- done  out  1  one-cycle completion strobe
- err  out  1  valid with done: range error or limit exhausted
- pulses_used  out  PW  pulses issued by last command; valid from done until next accept

## Operation
- States: IDLE, SETUP, PULSE, RECOVER, VERIFY, DONE.
- IDLE: cmd_ready=1. On accept, latch all cmd fields.
- Range check at accept: PROGRAM with cmd_row>=ROWS or cmd_col>=COLS -> DONE with err=1, pulses_used=0, no selects/enables ever asserted.
- SETUP: prog_mode=1; PROGRAM drives row_sel/col_sel one-hot at latched address; TUNNEL drives all selects 0. Hold SETTLE cycles -> PULSE.
- PULSE: vinj_en=1 (PROGRAM) or tun_en=1 (TUNNEL) for exactly pulse_len cycles; pulse counter increments on PULSE entry.
- RECOVER: enables low, selects and prog_mode held; SETTLE cycles.
- TUNNEL after RECOVER -> DONE, err=0, pulses_used=1 (single pulse, no verify).
- PROGRAM after RECOVER -> VERIFY (1 cycle, sample verify_hit):
  - hit -> DONE, err=0.
  - no hit, count<max -> PULSE directly (no new SETUP).
  - no hit, count==max -> DONE, err=1.
- DONE: one cycle; done=1, selects/prog_mode/enables 0; then IDLE.
- vinj_en and tun_en never both high; no enable ever high outside PULSE.
- Counters PW bits; pulse_len and max at 2^PW-1 must not wrap.

## Timing
- Reset (rst_n=0 at edge): state IDLE; row_sel, col_sel, prog_mode, vinj_en, tun_en, busy, done, err, pulses_used all 0; cmd_ready=1 from first IDLE cycle.
- Reset mid-command: all outputs 0 at next edge, command abandoned, no done.
- Accept at edge T: busy=1 and SETUP outputs from T+1; first enable at T+1+SETTLE.
- PROGRAM hit on first verify: done at T+1+2*SETTLE+pulse_len+1 (VERIFY) +1.
- Each extra pulse costs pulse_len+SETTLE+1 cycles.
- verify_hit ignored outside VERIFY. cmd_* ignored while busy.
- Back-to-back: next command accepted the cycle after DONE (IDLE).

## Configuration
- FG_PROG_VERIFY_EN defined: VERIFY state and verify_hit used as above.
- Undefined: open-loop; PROGRAM issues exactly max pulses (RECOVER -> PULSE until count==max, then DONE), verify_hit ignored, err only on range error, pulses_used=max.

## Test plan
- PROGRAM row 3 col 10, len 5, max 4, SETTLE 4, verify_hit high at first VERIFY -> row_sel=8'h08, col_sel=16'h0400, vinj_en high exactly 5 cycles, done with err=0, pulses_used=1, done at accept+16.
- Same, verify_hit never high -> 4 pulses, SETUP once, done err=1, pulses_used=4 (with macro); without macro pulses_used=4, err=0.
- TUNNEL len 100 -> selects all 0, prog_mode high, tun_en 100 cycles, vinj_en never high, done err=0, pulses_used=1.
- PROGRAM row 9 with ROWS=8 -> done 2 cycles after accept, err=1, no select/enable asserted.
- Reset asserted mid-PULSE -> next cycle all outputs 0, cmd_ready=1, no done; new command then completes normally.
- cmd_pulse_len=0, cmd_max_pulses=0 -> one pulse of 1 cycle; cmd_valid held high during busy accepts nothing until IDLE.
